// File: rtl/seg_display_scanner.sv
// Multiplexed hex 7-segment scanner: shadow register, leading-zero blanking, registered outputs.
// Optional anode PWM dimming is enabled by defining SEG_SCAN_BRIGHTNESS_EN.
module seg_display_scanner #(
   parameter int DIGITS   = 4,
   parameter int DIV_BITS = 18
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [4*DIGITS-1:0] number,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                load,
   input  logic                blank_lz,
   input  logic [3:0]          brightness,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   an
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   logic [DIV_BITS-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] num_q, num_d;
   logic [DIGITS-1:0]   sdp_q, sdp_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic       tick;
   logic       duty_on;
   logic       blank;
   logic       zero_run;
   logic       cur_dp;
   logic       cur_lz;
   logic [3:0] cur_digit;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

`ifdef SEG_SCAN_BRIGHTNESS_EN
   // Top four prescaler bits form the PWM phase; the shift form also tolerates tiny DIV_BITS.
   logic [3:0] duty_phase;
   assign duty_phase = 4'(({4'b0000, presc_q} << 4) >> DIV_BITS);
   assign duty_on    = (duty_phase <= brightness);
`else
   logic [3:0] unused_brightness;
   assign unused_brightness = brightness;
   assign duty_on           = 1'b1;
`endif

   always_comb begin
      tick    = &presc_q;
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      num_d = load ? number : num_q;
      sdp_d = load ? dp_in : sdp_q;
   end

   // Walk from the most significant digit down so zero_run means "this and all higher digits are 0".
   always_comb begin
      cur_digit = 4'h0;
      cur_dp    = 1'b0;
      cur_lz    = 1'b0;
      zero_run  = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (num_q[4*k +: 4] == 4'h0);
         if (idx_q == IDX_W'(k)) begin
            cur_digit = num_q[4*k +: 4];
            cur_dp    = sdp_q[k];
            cur_lz    = zero_run;
         end
      end
      blank = blank_lz && (idx_q != '0) && cur_lz && !cur_dp;

      an_d = '1;
      for (int k = 0; k < DIGITS; k++) begin
         an_d[k] = !(duty_on && !blank && (idx_q == IDX_W'(k)));
      end
      seg_d = blank ? 7'h7F : glyph(cur_digit);
      dp_d  = blank ? 1'b1 : !cur_dp;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         presc_q <= '0;
         idx_q   <= '0;
         num_q   <= '0;
         sdp_q   <= '0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= '1;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         sdp_q   <= sdp_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: cycle model compared every cycle on two instances
// (DIV_BITS=2 and DIV_BITS=4), plus literal expectations for the scan scenarios.
module tb_seg_display_scanner;
   logic        clk = 1'b0;
   logic        RESET;
   logic [15:0] number;
   logic [3:0]  dp_in;
   logic        load;
   logic        blank_lz;
   logic [3:0]  brightness;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;
   logic [3:0]  an_a, an_b;

   int checks = 0;
   int errors = 0;

   // model state: cycles since the last reset edge, and the shadow contents
   int          t = 0;
   logic        mvalid = 1'b0;
   logic [15:0] m_sh = '0;
   logic [3:0]  m_sdp = '0;
   logic [11:0] exp_a, exp_b;

   logic [3:0] an_seq [4];
   logic [6:0] seg_seq [4];

   always #5 clk = ~clk;

   seg_display_scanner #(.DIGITS(4), .DIV_BITS(2)) dut_a (
      .CLK(clk), .RESET(RESET), .number(number), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .brightness(brightness), .seg(seg_a), .dp(dp_a), .an(an_a)
   );

   seg_display_scanner #(.DIGITS(4), .DIV_BITS(4)) dut_b (
      .CLK(clk), .RESET(RESET), .number(number), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .brightness(brightness), .seg(seg_b), .dp(dp_b), .an(an_b)
   );

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Display content for cycle tt of a scan with slot length 2^d: {an, seg, dp}
   function automatic logic [11:0] model_out(input int d, input int tt, input logic [15:0] sh,
                                             input logic [3:0] sdp, input logic blz,
                                             input logic [3:0] br);
      int         idx;
      int         p;
      logic [3:0] an_v;
      idx = (tt >> d) % 4;
      p   = tt % (1 << d);
      if (blz && idx > 0 && (sh >> (4 * idx)) == 16'd0 && !sdp[idx])
         return {4'hF, 7'h7F, 1'b1};
      an_v      = 4'hF;
      an_v[idx] = 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      if (((p * 16) >> d) > int'(br)) an_v = 4'hF;
`else
      if (p < 0 || br > 4'hF) an_v = 4'hF;
`endif
      return {an_v, glyph(sh[idx*4 +: 4]), ~sdp[idx]};
   endfunction

   always @(posedge clk) begin
      if (!RESET) begin
         t      <= 0;
         m_sh   <= '0;
         m_sdp  <= '0;
         exp_a  <= {4'hF, 7'h7F, 1'b1};
         exp_b  <= {4'hF, 7'h7F, 1'b1};
         mvalid <= 1'b1;
      end else if (mvalid) begin
         exp_a <= model_out(2, t, m_sh, m_sdp, blank_lz, brightness);
         exp_b <= model_out(4, t, m_sh, m_sdp, blank_lz, brightness);
         t     <= t + 1;
         if (load) begin
            m_sh  <= number;
            m_sdp <= dp_in;
         end
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL scan_a t=%0d got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     t, an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
         checks++;
         if ({an_b, seg_b, dp_b} !== exp_b) begin
            errors++;
            $display("FAIL scan_b t=%0d got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     t, an_b, seg_b, dp_b, exp_b[11:8], exp_b[7:1], exp_b[0]);
         end
      end
   end

   task automatic lit(input string name, input logic [15:0] got, input logic [15:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, expv);
      end
   endtask

   task automatic pulse_load(input logic [15:0] n, input logic [3:0] d);
      number = n;
      dp_in  = d;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf;
      int ph;
      bit found;
      an_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_seq = '{7'h19, 7'h30, 7'h24, 7'h79};
      RESET = 1'b0; load = 1'b0; number = '0; dp_in = '0; blank_lz = 1'b0; brightness = 4'hF;

      // three reset edges, then release
      repeat (3) @(negedge clk);
      RESET = 1'b1;
      lit("rst_out", {an_a, seg_a, dp_a}, {4'hF, 7'h7F, 1'b1});
      @(negedge clk);
      lit("post_rst_an", an_a, 4'hE);
      lit("post_rst_seg", seg_a, 7'h40);

      // plain scan of 1234
      pulse_load(16'h1234, 4'h0);
      repeat (16) begin
         @(negedge clk);
         ph = ((t - 1) >> 2) % 4;
         lit("scan1234_an", an_a, an_seq[ph]);
         lit("scan1234_seg", seg_a, seg_seq[ph]);
         lit("scan1234_dp", dp_a, 1'b1);
      end

      // leading-zero blanking of 0050
      blank_lz = 1'b1;
      pulse_load(16'h0050, 4'h0);
      nf = 0;
      repeat (16) begin
         @(negedge clk);
         if (an_a == 4'hF) nf++;
         if (an_a == 4'hD) lit("lz_slot1_seg", seg_a, 7'h12);
         if (an_a == 4'hE) lit("lz_slot0_seg", seg_a, 7'h40);
      end
      lit("lz_blank_cycles", 16'(nf), 16'd8);

      // a lit decimal point keeps digit 3 visible
      pulse_load(16'h0050, 4'b1000);
      nf = 0;
      repeat (16) begin
         @(negedge clk);
         if (an_a == 4'hF) nf++;
         if (an_a == 4'h7) lit("lz_dp_slot3", {seg_a, dp_a}, {7'h40, 1'b0});
      end
      lit("lz_dp_blank_cycles", 16'(nf), 16'd4);

      // number changes without load must not reach the display
      number = 16'h9999;
      repeat (8) @(negedge clk);

      // mid-slot load
      blank_lz = 1'b0;
      number   = 16'hFFFF;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      lit("preload_seg_not_F", 16'(seg_a != 7'h0E), 16'd1);
      @(negedge clk);
      lit("midload_seg", seg_a, 7'h0E);
      repeat (6) @(negedge clk);

      // one reset edge during slot 2
      found = 1'b0;
      for (int i = 0; i < 24 && !found; i++) begin
         @(negedge clk);
         if ((((t - 1) >> 2) % 4) == 2) found = 1'b1;
      end
      lit("find_slot2", 16'(found), 16'd1);
      RESET = 1'b0;
      @(negedge clk);
      RESET = 1'b1;
      lit("midrst_out", {an_a, seg_a, dp_a}, {4'hF, 7'h7F, 1'b1});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         lit("midrst_slot0", {an_a, seg_a}, {4'hE, 7'h40});
      end
      @(negedge clk);
      lit("midrst_slot1", {an_a, seg_a}, {4'hD, 7'h40});

      // brightness on the 16-cycle-slot instance
      pulse_load(16'h1234, 4'h0);
      brightness = 4'h0;
      nf = 0;
      repeat (16) begin
         @(negedge clk);
         if (an_b != 4'hF) nf++;
      end
`ifdef SEG_SCAN_BRIGHTNESS_EN
      lit("duty_b0", 16'(nf), 16'd1);
`else
      lit("duty_b0", 16'(nf), 16'd16);
`endif
      brightness = 4'hF;
      nf = 0;
      repeat (16) begin
         @(negedge clk);
         if (an_b != 4'hF) nf++;
      end
      lit("duty_b15", 16'(nf), 16'd16);
      brightness = 4'h7;
      repeat (40) @(negedge clk);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
